// File: rtl/decode_hazard_ctrl.sv
// Decode-stage scoreboard: per-register in-flight write counters, RAW/saturation stall, flush and halt drain.
// Combinational stall/fire from registered counters; state updates on the next rising edge.
module decode_hazard_ctrl #(
    parameter int NUMREGISTERS = 8,
    parameter int REGW         = 3,
    parameter int MAXPEND      = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    issue_valid,
    input  logic [REGW-1:0]         rd_reg1,
    input  logic [REGW-1:0]         rd_reg2,
    input  logic                    use_reg1,
    input  logic                    use_reg2,
    input  logic                    issue_wr_en,
    input  logic [REGW-1:0]         issue_wr_reg,
    input  logic                    issue_halt,
    input  logic                    wb_valid,
    input  logic [REGW-1:0]         wb_reg,
    input  logic                    flush,
    output logic                    stall,
    output logic                    issue_fire,
    output logic                    halted,
    output logic [NUMREGISTERS-1:0] pending_mask,
    output logic                    wb_err
);

    localparam int CNTW = $clog2(MAXPEND + 1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNTW-1:0]        r_cnt     [NUMREGISTERS];
    logic [CNTW-1:0]        w_cnt_nxt [NUMREGISTERS];
    logic                   r_wb_err;
    logic [NUMREGISTERS-1:0] w_inc;
    logic [NUMREGISTERS-1:0] w_dec;
    logic                   w_raw;
    logic                   w_sat;
    logic                   w_flush_eff;
    logic                   w_wb_zero;
    logic                   w_all_zero_nxt;

    // Flush has no effect once halted; only reset leaves HALTED.
    assign w_flush_eff = flush && (r_state != S_HALTED);

    assign w_raw = (use_reg1 && (r_cnt[rd_reg1] != '0)) ||
                   (use_reg2 && (r_cnt[rd_reg2] != '0));
    assign w_sat = issue_wr_en && (r_cnt[issue_wr_reg] == CNTW'(MAXPEND));

    assign stall      = issue_valid && (w_raw || w_sat || (r_state != S_RUN) || flush);
    assign issue_fire = issue_valid && !stall;
    assign halted     = (r_state == S_HALTED);
    assign wb_err     = r_wb_err;

    assign w_wb_zero = wb_valid && (r_cnt[wb_reg] == '0) && !w_flush_eff;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < NUMREGISTERS; i++) begin
            w_inc[i] = issue_fire && issue_wr_en && (issue_wr_reg == REGW'(i));
            w_dec[i] = wb_valid && (wb_reg == REGW'(i)) && (r_cnt[i] != '0);
        end
    end

    always_comb begin
        w_all_zero_nxt = 1'b1;
        for (int i = 0; i < NUMREGISTERS; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_flush_eff) begin
                w_cnt_nxt[i] = '0;
            end else if (w_inc[i] && !w_dec[i]) begin
                w_cnt_nxt[i] = r_cnt[i] + CNTW'(1);
            end else if (w_dec[i] && !w_inc[i]) begin
                w_cnt_nxt[i] = r_cnt[i] - CNTW'(1);
            end
            if (w_cnt_nxt[i] != '0) begin
                w_all_zero_nxt = 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUMREGISTERS; i++) begin
            pending_mask[i] = (r_cnt[i] != '0);
        end
    end

    // Drain completes on the edge where the last outstanding write retires.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (issue_fire && issue_halt) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (flush) begin
                    w_state_nxt = S_RUN;
                end else if (w_all_zero_nxt) begin
                    w_state_nxt = S_HALTED;
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_RUN;
            r_wb_err <= 1'b0;
            for (int i = 0; i < NUMREGISTERS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_wb_zero) begin
                r_wb_err <= 1'b1;
            end
            for (int i = 0; i < NUMREGISTERS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed bench for decode_hazard_ctrl: driver queues expected per-cycle outputs, monitor compares at negedge.
module tb_decode_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       issue_valid;
    logic [2:0] rd_reg1;
    logic [2:0] rd_reg2;
    logic       use_reg1;
    logic       use_reg2;
    logic       issue_wr_en;
    logic [2:0] issue_wr_reg;
    logic       issue_halt;
    logic       wb_valid;
    logic [2:0] wb_reg;
    logic       flush;
    logic       stall;
    logic       issue_fire;
    logic       halted;
    logic [7:0] pending_mask;
    logic       wb_err;

    typedef struct {
        logic       stall;
        logic       fire;
        logic       halted;
        logic [7:0] mask;
        logic       err;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errs   = 0;

    decode_hazard_ctrl #(
        .NUMREGISTERS(8),
        .REGW        (3),
        .MAXPEND     (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .rd_reg1     (rd_reg1),
        .rd_reg2     (rd_reg2),
        .use_reg1    (use_reg1),
        .use_reg2    (use_reg2),
        .issue_wr_en (issue_wr_en),
        .issue_wr_reg(issue_wr_reg),
        .issue_halt  (issue_halt),
        .wb_valid    (wb_valid),
        .wb_reg      (wb_reg),
        .flush       (flush),
        .stall       (stall),
        .issue_fire  (issue_fire),
        .halted      (halted),
        .pending_mask(pending_mask),
        .wb_err      (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr();
        issue_valid  = 1'b0;
        rd_reg1      = 3'd0;
        rd_reg2      = 3'd0;
        use_reg1     = 1'b0;
        use_reg2     = 1'b0;
        issue_wr_en  = 1'b0;
        issue_wr_reg = 3'd0;
        issue_halt   = 1'b0;
        wb_valid     = 1'b0;
        wb_reg       = 3'd0;
        flush        = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic push_exp(input logic s, input logic f, input logic h,
                            input logic [7:0] m, input logic e, input string nm);
        exp_t x;
        x.stall  = s;
        x.fire   = f;
        x.halted = h;
        x.mask   = m;
        x.err    = e;
        x.name   = nm;
        exp_q.push_back(x);
    endtask

    task automatic wr(input logic [2:0] r);
        issue_valid  = 1'b1;
        issue_wr_en  = 1'b1;
        issue_wr_reg = r;
    endtask

    task automatic rd1(input logic [2:0] r);
        issue_valid = 1'b1;
        use_reg1    = 1'b1;
        rd_reg1     = r;
    endtask

    task automatic wb(input logic [2:0] r);
        wb_valid = 1'b1;
        wb_reg   = r;
    endtask

    // Monitor: one expected record per cycle, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t x;
                x = exp_q.pop_front();
                n_checks++;
                if (stall !== x.stall || issue_fire !== x.fire || halted !== x.halted ||
                    pending_mask !== x.mask || wb_err !== x.err) begin
                    n_errs++;
                    $display("FAIL %s: got stall=%b fire=%b halted=%b mask=%h err=%b, want stall=%b fire=%b halted=%b mask=%h err=%b",
                             x.name, stall, issue_fire, halted, pending_mask, wb_err,
                             x.stall, x.fire, x.halted, x.mask, x.err);
                end
            end
        end
    end

    initial begin
        int guard;
        rst_n = 1'b0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp(0, 0, 0, 8'h00, 0, "reset_state");

        // RAW on r3, cleared by writeback one cycle later
        nxt(); wr(3);             push_exp(0, 1, 0, 8'h00, 0, "raw_wr_r3");
        nxt(); rd1(3);            push_exp(1, 0, 0, 8'h08, 0, "raw_rd_stall");
        nxt(); rd1(3);            push_exp(1, 0, 0, 8'h08, 0, "raw_rd_stall2");
        nxt(); rd1(3); wb(3);     push_exp(1, 0, 0, 8'h08, 0, "raw_wb_same_cycle");
        nxt(); rd1(3);            push_exp(0, 1, 0, 8'h00, 0, "raw_rd_fire");

        // Saturation on r5
        nxt(); wr(5);             push_exp(0, 1, 0, 8'h00, 0, "sat_wr1");
        nxt(); wr(5);             push_exp(0, 1, 0, 8'h20, 0, "sat_wr2");
        nxt(); wr(5);             push_exp(0, 1, 0, 8'h20, 0, "sat_wr3");
        nxt(); wr(5);             push_exp(1, 0, 0, 8'h20, 0, "sat_wr4_stall");
        nxt(); wr(5); wb(5);      push_exp(1, 0, 0, 8'h20, 0, "sat_wb_same_cycle");
        nxt(); wr(5);             push_exp(0, 1, 0, 8'h20, 0, "sat_wr4_fire");
        nxt(); wb(5);             push_exp(0, 0, 0, 8'h20, 0, "sat_drain1");
        nxt(); wb(5);             push_exp(0, 0, 0, 8'h20, 0, "sat_drain2");
        nxt(); wb(5);             push_exp(0, 0, 0, 8'h20, 0, "sat_drain3");

        // Simultaneous inc and dec on r2
        nxt(); wr(2);             push_exp(0, 1, 0, 8'h00, 0, "incdec_wr");
        nxt(); wr(2); wb(2);      push_exp(0, 1, 0, 8'h04, 0, "incdec_both");
        nxt();                    push_exp(0, 0, 0, 8'h04, 0, "incdec_hold");
        nxt(); wb(2);             push_exp(0, 0, 0, 8'h04, 0, "incdec_wb");
        nxt();                    push_exp(0, 0, 0, 8'h00, 0, "incdec_empty");

        // Flush with concurrent issue and writeback
        nxt(); wr(1);             push_exp(0, 1, 0, 8'h00, 0, "flush_wr_r1");
        nxt(); wr(6);             push_exp(0, 1, 0, 8'h02, 0, "flush_wr_r6");
        nxt(); wr(0); wb(1); flush = 1'b1;
                                  push_exp(1, 0, 0, 8'h42, 0, "flush_cycle");
        nxt(); rd1(1);            push_exp(0, 1, 0, 8'h00, 0, "flush_after");

        // Halt drain
        nxt(); wr(4);             push_exp(0, 1, 0, 8'h00, 0, "halt_wr_r4");
        nxt(); issue_valid = 1'b1; issue_halt = 1'b1;
                                  push_exp(0, 1, 0, 8'h10, 0, "halt_fire");
        nxt(); issue_valid = 1'b1;
                                  push_exp(1, 0, 0, 8'h10, 0, "halt_drain_stall");
        nxt(); issue_valid = 1'b1; wb(4);
                                  push_exp(1, 0, 0, 8'h10, 0, "halt_drain_wb");
        nxt(); issue_valid = 1'b1;
                                  push_exp(1, 0, 1, 8'h00, 0, "halted_stall");
        nxt(); flush = 1'b1;      push_exp(0, 0, 1, 8'h00, 0, "halted_flush");
        nxt();                    push_exp(0, 0, 1, 8'h00, 0, "halted_sticky");

        // Async reset out of HALTED
        nxt(); rst_n = 1'b0;      push_exp(0, 0, 0, 8'h00, 0, "async_rst_halted");
        nxt(); rst_n = 1'b1;      push_exp(0, 0, 0, 8'h00, 0, "rst_release1");

        // Writeback with nothing pending
        nxt(); wb(7);             push_exp(0, 0, 0, 8'h00, 0, "wberr_cycle");
        nxt();                    push_exp(0, 0, 0, 8'h00, 1, "wberr_set");
        nxt(); wr(7);             push_exp(0, 1, 0, 8'h00, 1, "wberr_wr_r7");
        nxt();                    push_exp(0, 0, 0, 8'h80, 1, "wberr_sticky");
        nxt(); rst_n = 1'b0;      push_exp(0, 0, 0, 8'h00, 0, "async_rst_err");
        nxt(); rst_n = 1'b1;      push_exp(0, 0, 0, 8'h00, 0, "rst_release2");

        // Halt that also writes, then flush out of DRAIN
        nxt(); wr(0); issue_halt = 1'b1;
                                  push_exp(0, 1, 0, 8'h00, 0, "halt_wr_fire");
        nxt(); issue_valid = 1'b1;
                                  push_exp(1, 0, 0, 8'h01, 0, "halt_wr_drain");
        nxt(); flush = 1'b1;      push_exp(0, 0, 0, 8'h01, 0, "drain_flush");
        nxt(); wr(2);             push_exp(0, 1, 0, 8'h00, 0, "drain_back_to_run");
        nxt();

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errs++;
            $display("FAIL drain_queue: %0d expected records left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
